// File: rtl/countdown_timer.sv
// Key-driven MM:SS.cc countdown timer with debounced keys, 7-segment drive and status LEDs.
// Counts the preset down in 10 ms steps, then holds an alarm until a key press or timeout.
module countdown_timer #(
    parameter int DELAY_TIME_10MS = 500000,
    parameter int DEBOUNCE_TIME   = 1000000,
    parameter int ALARM_TIME      = 250000000
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_min_inc,
    input  logic       key_sec_inc,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       led3
);
    localparam int DBW = $clog2(DEBOUNCE_TIME + 1);
    localparam int PW  = $clog2(DELAY_TIME_10MS + 1);
    localparam int AW  = $clog2(ALARM_TIME + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] ALARM = 2'd3;

    // Key index 0 = start/pause, 1 = min_inc, 2 = sec_inc.
    logic [2:0]     keys, sync1, sync2, deb, press;
    logic [DBW-1:0] stab [3];

    assign keys = {key_sec_inc, key_min_inc, key_start_pause};

    always_ff @(posedge clk) begin
        if (!key_reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int i = 0; i < 3; i++) stab[i] <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == DBW'(DEBOUNCE_TIME - 1)) begin
                    stab[i] <= '0;
                    deb[i]  <= sync2[i];
                end else begin
                    stab[i] <= stab[i] + 1'b1;
                end
            end
        end
    end

    // Press fires in the cycle the debounced level is about to fall.
    always_comb begin
        for (int i = 0; i < 3; i++)
            press[i] = (sync2[i] != deb[i]) && (stab[i] == DBW'(DEBOUNCE_TIME - 1)) && !sync2[i];
    end

    logic [1:0]    state;
    logic [3:0]    pm1, pm0, ps1, ps0;
    logic [3:0]    cm1, cm0, cs1, cs0, cc1, cc0;
    logic [3:0]    dm1, dm0, ds1, ds0, dc1, dc0;
    logic [PW-1:0] presc;
    logic [AW-1:0] alarm_cnt;
    logic          tick, dec_zero, preset_nz;

    assign tick      = (presc == PW'(DELAY_TIME_10MS - 1));
    assign preset_nz = |{pm1, pm0, ps1, ps0};

    // BCD decrement by one centisecond; never evaluated at zero since that enters ALARM.
    always_comb begin
        {dm1, dm0, ds1, ds0, dc1, dc0} = {cm1, cm0, cs1, cs0, cc1, cc0};
        if (cc0 != 4'd0) dc0 = cc0 - 4'd1;
        else begin
            dc0 = 4'd9;
            if (cc1 != 4'd0) dc1 = cc1 - 4'd1;
            else begin
                dc1 = 4'd9;
                if (cs0 != 4'd0) ds0 = cs0 - 4'd1;
                else begin
                    ds0 = 4'd9;
                    if (cs1 != 4'd0) ds1 = cs1 - 4'd1;
                    else begin
                        ds1 = 4'd5;
                        if (cm0 != 4'd0) dm0 = cm0 - 4'd1;
                        else begin
                            dm0 = 4'd9;
                            dm1 = cm1 - 4'd1;
                        end
                    end
                end
            end
        end
        dec_zero = ({dm1, dm0, ds1, ds0, dc1, dc0} == 24'd0);
    end

    always_ff @(posedge clk) begin
        if (!key_reset) begin
            state     <= IDLE;
            {pm1, pm0, ps1, ps0} <= '0;
            {cm1, cm0, cs1, cs0, cc1, cc0} <= '0;
            presc     <= '0;
            alarm_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[0]) begin
                        if (preset_nz) begin
                            {cm1, cm0, cs1, cs0, cc1, cc0} <= {pm1, pm0, ps1, ps0, 8'h00};
                            presc <= '0;
                            state <= RUN;
                        end
                    end else if (press[1]) begin
                        if (pm0 == 4'd9) begin
                            pm0 <= 4'd0;
                            pm1 <= (pm1 == 4'd5) ? 4'd0 : pm1 + 4'd1;
                        end else pm0 <= pm0 + 4'd1;
                    end else if (press[2]) begin
                        if (ps0 == 4'd9) begin
                            ps0 <= 4'd0;
                            ps1 <= (ps1 == 4'd5) ? 4'd0 : ps1 + 4'd1;
                        end else ps0 <= ps0 + 4'd1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        {cm1, cm0, cs1, cs0, cc1, cc0} <= {dm1, dm0, ds1, ds0, dc1, dc0};
                        if (dec_zero) begin
                            state     <= ALARM;
                            alarm_cnt <= '0;
                        end else if (press[0]) state <= PAUSE;
                    end else if (press[0]) state <= PAUSE;
                end
                PAUSE: begin
                    if (press[0])      state <= RUN;
                    else if (press[1]) state <= IDLE;
                end
                default: begin
                    if ((|press) || alarm_cnt == AW'(ALARM_TIME - 1)) begin
                        state     <= IDLE;
                        alarm_cnt <= '0;
                    end else alarm_cnt <= alarm_cnt + 1'b1;
                end
            endcase
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    logic [23:0] show;
    always_comb begin
        case (state)
            IDLE:    show = {pm1, pm0, ps1, ps0, 8'h00};
            ALARM:   show = '0;
            default: show = {cm1, cm0, cs1, cs0, cc1, cc0};
        endcase
    end

    assign hex5 = seg(show[23:20]);
    assign hex4 = seg(show[19:16]);
    assign hex3 = seg(show[15:12]);
    assign hex2 = seg(show[11:8]);
    assign hex1 = seg(show[7:4]);
    assign hex0 = seg(show[3:0]);

    assign led0 = (state == ALARM);
    assign led1 = (state == RUN);
    assign led2 = (state == PAUSE);
    assign led3 = (state == IDLE) && preset_nz;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer with shortened tick, debounce and alarm times.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic key_reset, key_start_pause, key_min_inc, key_sec_inc;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic led0, led1, led2, led3;

    countdown_timer #(.DELAY_TIME_10MS(4), .DEBOUNCE_TIME(3), .ALARM_TIME(20)) dut (
        .clk(clk), .key_reset(key_reset), .key_start_pause(key_start_pause),
        .key_min_inc(key_min_inc), .key_sec_inc(key_sec_inc),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [45:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    wire [45:0] obs = {hex5, hex4, hex3, hex2, hex1, hex0, led3, led2, led1, led0};

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // leds = {led3, led2, led1, led0}
    function automatic logic [45:0] snap(input int mm, input int ss, input int cc, input logic [3:0] leds);
        return {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10), leds};
    endfunction

    task automatic push(input string tag, input logic [45:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_start_pause = v;
            1: key_min_inc     = v;
            default: key_sec_inc = v;
        endcase
    endtask

    // Returns right after the edge on which the press event is consumed.
    task automatic press_only(input int k);
        set_key(k, 1'b0);
        step(5);
        set_key(k, 1'b1);
    endtask

    task automatic press_settle(input int k, input int times);
        for (int i = 0; i < times; i++) begin
            press_only(k);
            step(6);
        end
    endtask

    localparam logic [3:0] L_IDLE = 4'b1000, L_RUN = 4'b0010, L_PAUSE = 4'b0100, L_ALARM = 4'b0001;

    initial begin
        key_reset = 1'b0;
        key_start_pause = 1'b1;
        key_min_inc = 1'b1;
        key_sec_inc = 1'b1;
        push("reset", snap(0, 0, 0, 4'b0000));
        step(2);
        check();
        key_reset = 1'b1;
        step(1);

        // Preset wrap
        press_settle(1, 60);
        push("min_wrap_00", snap(0, 0, 0, 4'b0000));
        check();
        press_settle(1, 1);
        push("min_01", snap(1, 0, 0, L_IDLE));
        check();
        press_settle(2, 59);
        push("sec_59", snap(1, 59, 0, L_IDLE));
        check();
        press_settle(2, 1);
        push("sec_wrap_00", snap(1, 0, 0, L_IDLE));
        check();

        // Debounce
        set_key(2, 1'b0);
        step(2);
        set_key(2, 1'b1);
        push("glitch", snap(1, 0, 0, L_IDLE));
        step(10);
        check();
        push("deb_before", snap(1, 0, 0, L_IDLE));
        set_key(2, 1'b0);
        step(4);
        check();
        push("deb_event", snap(1, 1, 0, L_IDLE));
        step(1);
        check();
        step(5);
        set_key(2, 1'b1);
        push("deb_once", snap(1, 1, 0, L_IDLE));
        step(10);
        check();

        // Countdown from 00:01
        press_settle(1, 59);
        push("preset_0001", snap(0, 1, 0, L_IDLE));
        check();
        press_only(0);
        push("run_start", snap(0, 1, 0, L_RUN));
        check();
        push("tick1", snap(0, 0, 99, L_RUN));
        step(4);
        check();
        push("tick2", snap(0, 0, 98, L_RUN));
        step(4);
        check();
        push("tick99", snap(0, 0, 1, L_RUN));
        step(391);
        check();
        push("alarm", snap(0, 0, 0, L_ALARM));
        step(1);
        check();
        push("alarm_hold", snap(0, 0, 0, L_ALARM));
        step(19);
        check();
        push("alarm_exit", snap(0, 1, 0, L_IDLE));
        step(1);
        check();

        // Borrow from 01:00
        press_settle(1, 1);
        press_settle(2, 59);
        push("preset_0100", snap(1, 0, 0, L_IDLE));
        check();
        press_only(0);
        push("borrow_pre", snap(1, 0, 0, L_RUN));
        step(3);
        check();
        push("borrow", snap(0, 59, 99, L_RUN));
        step(1);
        check();
        step(4);
        push("tick_98", snap(0, 59, 98, L_RUN));
        check();

        // Pause and resume: tick at pause edge-1 leaves prescaler at 1
        press_only(0);
        push("pause", snap(0, 59, 97, L_PAUSE));
        check();
        push("pause_hold", snap(0, 59, 97, L_PAUSE));
        step(50);
        check();
        press_only(0);
        push("resume", snap(0, 59, 97, L_RUN));
        check();
        push("resume_pre", snap(0, 59, 97, L_RUN));
        step(2);
        check();
        push("resume_tick", snap(0, 59, 96, L_RUN));
        step(1);
        check();
        step(10);
        press_only(0);
        step(10);
        press_only(1);
        push("cancel", snap(1, 0, 0, L_IDLE));
        check();

        // Priority: start_pause beats sec_inc
        step(10);
        key_start_pause = 1'b0;
        key_sec_inc = 1'b0;
        step(5);
        key_start_pause = 1'b1;
        key_sec_inc = 1'b1;
        push("prio_run", snap(1, 0, 0, L_RUN));
        check();
        step(10);
        key_reset = 1'b0;
        push("reset_run", snap(0, 0, 0, 4'b0000));
        step(1);
        check();
        key_reset = 1'b1;
        step(10);
        press_only(0);
        push("zero_start", snap(0, 0, 0, 4'b0000));
        check();
        step(6);

        // Maximum preset
        press_settle(1, 59);
        press_settle(2, 59);
        push("preset_5959", snap(59, 59, 0, L_IDLE));
        check();
        press_only(0);
        push("max_tick", snap(59, 58, 99, L_RUN));
        step(4);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Key-driven countdown timer for the DE1-SOC board, the down-counting counterpart to the stopwatch. The user presets minutes and seconds with two keys, then starts, pauses and resumes the countdown with a third key. The block counts MM:SS.cc down to zero in 10 ms steps and then raises an alarm LED. It debounces its own keys and drives the six common-anode 7-segment displays and the status LEDs directly.

## Interface
- DELAY_TIME_10MS, 500000: clk cycles per 10 ms tick (50 MHz).
- DEBOUNCE_TIME, 1000000: cycles a synchronized key level must stay stable before it is accepted (20 ms).
- ALARM_TIME, 250000000: cycles the ALARM state lasts before it returns to IDLE on its own (5 s).
- clk  input  1  50 MHz clock; all logic runs on its rising edge.
- key_reset  input  1  synchronous, active-low reset.
- key_start_pause  input  1  start/pause/resume key; active-low, asynchronous to clk.
- key_min_inc  input  1  preset-minute increment key, or cancel while paused; active-low.
- key_sec_inc  input  1  preset-second increment key; active-low.
- hex5..hex0  output  7 each  segment outputs in order minute-high, minute-low, second-high, second-low, centisecond-high, centisecond-low.
  - Bit order [6:0] = g..a, active low.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other value = 1111111.
- led0  output  1  alarm, high in ALARM.
- led1  output  1  running, high in RUN.
- led2  output  1  paused, high in PAUSE.
- led3  output  1  preset nonzero, high in IDLE when the preset is not 00:00.

## Operation
- Key conditioning, per key:
  - 2-flop synchronizer feeds a stability counter.
  - The debounced level updates after DEBOUNCE_TIME consecutive equal samples.
  - A debounced 1->0 transition produces a one-cycle press event.
- Event priority: start_pause > min_inc > sec_inc. Lower-priority events in the same cycle are dropped.
- Registers:
  - Preset: pm (0..59) and ps (0..59), both BCD.
  - Counter: 6 BCD digits holding MM:SS.cc.
  - Prescaler: 0..DELAY_TIME_10MS-1.
- State IDLE:
  - Display shows pm:ps.00.
  - min_inc: pm+1, wrapping 59->00. sec_inc: ps+1, wrapping 59->00.
  - start_pause with a nonzero preset: load counter = pm:ps.00, clear prescaler, go to RUN.
  - start_pause with a zero preset: ignored.
- State RUN:
  - Display shows the counter. The prescaler increments each cycle; at DELAY_TIME_10MS-1 it wraps to 0 and issues a tick.
  - Tick decrements the counter by 0.01 s with BCD borrow:
    - cc 00 -> 99 and borrow from seconds.
    - ss 00 -> 59 and borrow from minutes.
  - When the decremented value is 00:00.00, go to ALARM.
  - start_pause: go to PAUSE. min_inc and sec_inc are ignored.
- State PAUSE:
  - Prescaler and counter hold. Display shows the counter.
  - start_pause: go to RUN with the prescaler value preserved.
  - min_inc: go to IDLE (cancel); the preset is kept.
  - sec_inc: ignored.
- State ALARM:
  - Display shows 00:00.00 and led0=1. An alarm cycle counter runs.
  - Go to IDLE on any press event, or when the alarm counter reaches ALARM_TIME-1. The preset is kept.
- Reset (key_reset=0 at a clk edge, valid from any state, mid-count included):
  - State = IDLE; preset, counter, prescaler and alarm counter = 0.
  - Debounced levels = 1, stability counters = 0, synchronizers = 1.
  - Outputs: all hex = 1000000 (display 00:00.00), led0..led3 = 0.

## Timing
- Press event latency: a clean key fall yields a press event DEBOUNCE_TIME+2 cycles later.
  - A glitch shorter than DEBOUNCE_TIME produces no event.
  - A key held low produces exactly one event; release produces none.
- State, preset, counter and LED registers update on the clk edge of the event or tick. hex is a combinational decode of the displayed digits.
- The first tick comes DELAY_TIME_10MS cycles after the edge that enters RUN from IDLE.
- Tick and start_pause in the same RUN cycle: the decrement is applied and the state goes to PAUSE.
- If that decrement reaches zero, ALARM wins over PAUSE.
- Preset 00:00.01 equivalent: the minimum nonzero preset is 00:01, which runs 100 ticks to reach ALARM.
- Wrap at the top: 59:59.99 is not reachable. The maximum preset 59:59 decrements to 59:58.99.

## Test plan
Bench parameters: DELAY_TIME_10MS=4, DEBOUNCE_TIME=3, ALARM_TIME=20.
- Reset: assert key_reset=0 for 2 cycles -> hex0..hex5 = 1000000, led0..led3 = 0, state IDLE.
- Preset wrap: press min_inc 61 times -> pm=01 and hex5/hex4 show 0/1; press sec_inc 60 times -> ps=00; led3=1.
- Debounce: 2-cycle low glitch on sec_inc -> ps unchanged; clean low held 10 cycles -> ps+1 exactly once, 5 cycles after the fall.
- Countdown: preset 00:01, start -> led1=1, display 00:00.99 after 4 cycles, 00:00.98 after 8; after 400 cycles led0=1 and display 00:00.00; 20 cycles later IDLE with display 00:01.00.
- Borrow: preset 01:00, start -> after the first tick display 00:59.99.
- Pause/cancel and priority:
  - Pause mid-count -> counter holds for 50 cycles; resume -> the next tick arrives after the remaining prescaler count.
  - min_inc while paused -> IDLE with the preset kept.
  - start_pause and sec_inc presses in the same IDLE cycle -> RUN entered, ps unchanged.
  - key_reset low mid-RUN -> IDLE, display 00:00.00.
